// File: rtl/fifo_rd_unpack.sv
// Drains wide words from an FWFT FIFO read port and emits them LSB slice first as
// narrow valid/ready beats. Optional burst framing (out_last) under `STREAM_LAST_EN.
module fifo_rd_unpack #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  fifo_rd_data,
    input  logic                 fifo_rd_empty,
    output logic                 fifo_rd_ena,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef STREAM_LAST_EN
    output logic                 out_last,
`endif
    output logic                 busy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 1 || BURST_LEN < 1) begin : g_param_err
            $error("fifo_rd_unpack: illegal IN_WIDTH/OUT_WIDTH/BURST_LEN combination");
        end
    endgenerate

    logic [IN_WIDTH-1:0] r_hold;
    logic                r_hold_vld;
    logic [IDX_W-1:0]    r_idx;

    logic w_take;
    logic w_last_slice;
    logic w_pop;

    assign w_take       = r_hold_vld & out_ready;
    assign w_last_slice = (r_idx == LAST_IDX);
    // Refill overlaps the last slice so a steady stream has no bubble between words.
    assign w_pop        = rst_n & ~fifo_rd_empty & (~r_hold_vld | (w_take & w_last_slice));

    assign fifo_rd_ena = w_pop;
    assign out_valid   = r_hold_vld;
    assign busy        = r_hold_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld <= 1'b0;
            r_idx      <= '0;
        end else if (w_pop) begin
            r_hold_vld <= 1'b1;
            r_idx      <= '0;
        end else if (w_take && w_last_slice) begin
            r_hold_vld <= 1'b0;
            r_idx      <= '0;
        end else if (w_take) begin
            r_idx      <= r_idx + 1'b1;
        end
    end

    // Data register needs no reset: it is only observed while r_hold_vld is set.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_hold <= fifo_rd_data;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_idx == IDX_W'(i)) begin
                out_data = r_hold[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

`ifdef STREAM_LAST_EN
    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BURST_LEN - 1);

    logic [BC_W-1:0] r_bcnt;

    // Burst position follows accepted beats only, independent of word boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
        end else if (w_take) begin
            r_bcnt <= (r_bcnt == BC_LAST) ? '0 : r_bcnt + 1'b1;
        end
    end

    assign out_last = r_hold_vld & (r_bcnt == BC_LAST);
`endif

endmodule
